// File: rtl/cpu_bus_ctrl.sv
// cpu_bus_ctrl
// ------------
// Bus-cycle controller sitting directly behind the CPU wrapper. It watches the
// wrapper's strobes, address and function code, generates DTACK with
// region-based wait states, runs a bus-error watchdog, and decodes
// interrupt-acknowledge cycles. Wait states and the watchdog are counted in
// phi1_ce ticks, so timing is the same whichever CPU core drives the wrapper.
//
// Address regions (address[23:20]):
//   0x000000-0xBFFFFF  RAM  RAM_WS wait ticks
//   0xC00000-0xEFFFFF  IO   acknowledged by the io_ack level
//   0xF00000-0xFFFFFF  ROM  ROM_WS wait ticks
//
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   phi1_ce     in   CPU phase-1 clock enable, qualifies all counting
//   AS_n        in   address strobe
//   UDS_n       in   upper data strobe
//   LDS_n       in   lower data strobe
//   rw_n        in   1 = read, 0 = write
//   address     in   24-bit CPU byte address
//   FC          in   function code, 3'b111 marks an IACK cycle
//   io_ack      in   I/O device ready (level)
//   dTACK_n     out  data transfer acknowledge
//   buserr      out  bus error, held until AS_n negates
//   iack_n      out  low during an IACK cycle
//   iack_level  out  level being acknowledged (address[3:1])
//   io_sel      out  high while an I/O-region cycle is in progress
//   cyc_write   out  ~rw_n captured at the start of the current cycle

module cpu_bus_ctrl #(
    parameter int RAM_WS  = 0,
    parameter int ROM_WS  = 2,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        phi1_ce,
    input  logic        AS_n,
    input  logic        UDS_n,
    input  logic        LDS_n,
    input  logic        rw_n,
    input  logic [23:0] address,
    input  logic [2:0]  FC,
    input  logic        io_ack,
    output logic        dTACK_n,
    output logic        buserr,
    output logic        iack_n,
    output logic [2:0]  iack_level,
    output logic        io_sel,
    output logic        cyc_write
);

    localparam int WS_W = 8;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_ACK  = 3'd2;
    localparam logic [2:0] ST_ERR  = 3'd3;
    localparam logic [2:0] ST_IACK = 3'd4;

    localparam logic [1:0] REGION_RAM = 2'd0;
    localparam logic [1:0] REGION_ROM = 2'd1;
    localparam logic [1:0] REGION_IO  = 2'd2;

    logic [2:0]      state_reg;
    logic [1:0]      region_reg;
    logic [WS_W-1:0] ws_cnt_reg;
    logic [TO_W-1:0] to_cnt_reg;
    logic            dtack_n_reg;
    logic            buserr_reg;
    logic            iack_n_reg;
    logic [2:0]      iack_level_reg;
    logic            io_sel_reg;
    logic            cyc_write_reg;

    logic            is_iack;
    logic            start_cyc;
    logic [1:0]      addr_region;
    logic            ack_cond;
    logic            to_hit;

    // Only the region nibble and the IACK level bits are decoded.
    logic unused_addr;
    assign unused_addr = ^{address[19:4], address[0]};

    assign is_iack   = (FC == 3'b111);
    // An IACK cycle may run without data strobes, so FC=7 alone qualifies.
    assign start_cyc = ~AS_n & (~UDS_n | ~LDS_n | is_iack);

    always_comb begin
        addr_region = REGION_RAM;
        case (address[23:20])
            4'hF:             addr_region = REGION_ROM;
            4'hC, 4'hD, 4'hE: addr_region = REGION_IO;
            default:          addr_region = REGION_RAM;
        endcase
    end

    assign ack_cond = (region_reg == REGION_IO) ? io_ack : (ws_cnt_reg == '0);
    assign to_hit   = (to_cnt_reg == TO_W'(TIMEOUT));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            region_reg     <= REGION_RAM;
            ws_cnt_reg     <= '0;
            to_cnt_reg     <= '0;
            dtack_n_reg    <= 1'b1;
            buserr_reg     <= 1'b0;
            iack_n_reg     <= 1'b1;
            iack_level_reg <= 3'd0;
            io_sel_reg     <= 1'b0;
            cyc_write_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_cyc) begin
                        if (is_iack) begin
                            state_reg      <= ST_IACK;
                            iack_n_reg     <= 1'b0;
                            iack_level_reg <= address[3:1];
                        end else begin
                            state_reg     <= ST_WAIT;
                            region_reg    <= addr_region;
                            // IO ignores ws_cnt; it waits on io_ack instead.
                            ws_cnt_reg    <= (addr_region == REGION_ROM) ?
                                             WS_W'(ROM_WS) : WS_W'(RAM_WS);
                            to_cnt_reg    <= '0;
                            cyc_write_reg <= ~rw_n;
                            io_sel_reg    <= (addr_region == REGION_IO);
                        end
                    end
                end

                ST_WAIT: begin
                    if (AS_n) begin
                        // CPU gave up on the cycle: return silently.
                        state_reg  <= ST_IDLE;
                        io_sel_reg <= 1'b0;
                    end else if (ack_cond) begin
                        // Checked ahead of the timeout so a late ack still wins.
                        state_reg   <= ST_ACK;
                        dtack_n_reg <= 1'b0;
                    end else if (to_hit) begin
                        state_reg  <= ST_ERR;
                        buserr_reg <= 1'b1;
                    end else if (phi1_ce) begin
                        if (ws_cnt_reg != '0) begin
                            ws_cnt_reg <= ws_cnt_reg - WS_W'(1);
                        end
                        // Reaching TIMEOUT leaves WAIT before the next
                        // increment, so to_cnt saturates there.
                        to_cnt_reg <= to_cnt_reg + TO_W'(1);
                    end
                end

                ST_ACK: begin
                    // Strobe changes are ignored; only AS_n ends the cycle.
                    if (AS_n) begin
                        state_reg   <= ST_IDLE;
                        dtack_n_reg <= 1'b1;
                        io_sel_reg  <= 1'b0;
                    end
                end

                ST_ERR: begin
                    if (AS_n) begin
                        state_reg  <= ST_IDLE;
                        buserr_reg <= 1'b0;
                        io_sel_reg <= 1'b0;
                    end
                end

                ST_IACK: begin
                    // No DTACK and no watchdog here: the autovector arrives
                    // through VPA elsewhere. iack_level is left as captured.
                    if (AS_n) begin
                        state_reg  <= ST_IDLE;
                        iack_n_reg <= 1'b1;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign dTACK_n    = dtack_n_reg;
    assign buserr     = buserr_reg;
    assign iack_n     = iack_n_reg;
    assign iack_level = iack_level_reg;
    assign io_sel     = io_sel_reg;
    assign cyc_write  = cyc_write_reg;

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Testbench for cpu_bus_ctrl with default parameters
// (RAM_WS=0, ROM_WS=2, TIMEOUT=255). phi1_ce is high one clk in four.
// A table of bus cycles is applied in a loop; each cycle pushes its expected
// outcome onto a scoreboard queue that a monitor pops when the DUT asserts
// DTACK, bus error or IACK. Hand-written sequences cover abort, reset,
// strobe changes during ACK and back-to-back cycles.

module tb_cpu_bus_ctrl;

    localparam int K_MEM  = 0;
    localparam int K_IO   = 1;
    localparam int K_ERR  = 2;
    localparam int K_IACK = 3;

    localparam int EV_DTACK = 0;
    localparam int EV_BERR  = 1;
    localparam int EV_IACK  = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        phi1_ce = 1'b0;
    logic        AS_n;
    logic        UDS_n;
    logic        LDS_n;
    logic        rw_n;
    logic [23:0] address;
    logic [2:0]  FC;
    logic        io_ack;
    logic        dTACK_n;
    logic        buserr;
    logic        iack_n;
    logic [2:0]  iack_level;
    logic        io_sel;
    logic        cyc_write;

    cpu_bus_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .phi1_ce    (phi1_ce),
        .AS_n       (AS_n),
        .UDS_n      (UDS_n),
        .LDS_n      (LDS_n),
        .rw_n       (rw_n),
        .address    (address),
        .FC         (FC),
        .io_ack     (io_ack),
        .dTACK_n    (dTACK_n),
        .buserr     (buserr),
        .iack_n     (iack_n),
        .iack_level (iack_level),
        .io_sel     (io_sel),
        .cyc_write  (cyc_write)
    );

    always #5 clk = ~clk;

    // phi1_ce: one clk in four, changed on the falling edge.
    int ce_div = 0;
    always @(negedge clk) begin
        ce_div  = (ce_div + 1) % 4;
        phi1_ce = (ce_div == 0);
    end

    typedef struct {
        logic [23:0] addr;
        logic [2:0]  fc;
        logic        rw_n;
        logic        uds_n;
        logic        lds_n;
        int          kind;
        int          ticks;      // wait ticks / io_ack delay / timeout / IACK watch
        logic        exp_write;
        logic        exp_io;
        logic [2:0]  exp_level;
    } vec_t;

    typedef struct {
        int         ev;
        logic       w;
        logic       io;
        logic [2:0] lvl;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_check(input int ev);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_unexpected: got event %0d, required none", ev);
        end else begin
            e = sb_q.pop_front();
            chk("sb_event", 32'(ev), 32'(e.ev));
            if (ev == EV_IACK) begin
                chk("sb_level", 32'(iack_level), 32'(e.lvl));
            end else begin
                chk("sb_write", 32'(cyc_write), 32'(e.w));
                chk("sb_io", 32'(io_sel), 32'(e.io));
            end
            $display("scoreboard: event %0d matched, %0d pending", ev, sb_q.size());
        end
    endtask

    // Monitor: catches every DTACK / bus error / IACK assertion.
    logic prev_dtack = 1'b1;
    logic prev_berr  = 1'b0;
    logic prev_iack  = 1'b1;
    always @(negedge clk) begin
        if (reset_n) begin
            if (prev_dtack && !dTACK_n) sb_check(EV_DTACK);
            if (!prev_berr && buserr)   sb_check(EV_BERR);
            if (prev_iack && !iack_n)   sb_check(EV_IACK);
        end
        prev_dtack = dTACK_n;
        prev_berr  = buserr;
        prev_iack  = iack_n;
    end

    task automatic check_idle(input string tag);
        chk({tag, "_dtack"}, 32'(dTACK_n), 32'd1);
        chk({tag, "_buserr"}, 32'(buserr), 32'd0);
        chk({tag, "_iack_n"}, 32'(iack_n), 32'd1);
        chk({tag, "_io_sel"}, 32'(io_sel), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exp_t  e;
        int    ticks;
        string t;
        t = $sformatf("v%0d", idx);
        e.ev  = (v.kind == K_ERR) ? EV_BERR : (v.kind == K_IACK) ? EV_IACK : EV_DTACK;
        e.w   = v.exp_write;
        e.io  = v.exp_io;
        e.lvl = v.exp_level;
        sb_q.push_back(e);

        @(negedge clk);
        address = v.addr; FC = v.fc; rw_n = v.rw_n;
        UDS_n = v.uds_n; LDS_n = v.lds_n; io_ack = 1'b0; AS_n = 1'b0;
        @(posedge clk);             // start sampled: DUT enters WAIT/IACK
        ticks = 0;
        if (v.kind == K_IACK) begin
            @(negedge clk);
            chk({t, "_iack_n"}, 32'(iack_n), 32'd0);
            chk({t, "_iack_level"}, 32'(iack_level), 32'(v.exp_level));
            while (ticks < v.ticks) begin
                @(posedge clk);
                if (phi1_ce) ticks++;
            end
            @(negedge clk);
            chk({t, "_iack_dtack"}, 32'(dTACK_n), 32'd1);
            chk({t, "_iack_buserr"}, 32'(buserr), 32'd0);
            chk({t, "_iack_held"}, 32'(iack_n), 32'd0);
        end else begin
            while (ticks < v.ticks) begin
                @(posedge clk);
                if (phi1_ce) ticks++;
            end
            @(negedge clk);
            chk({t, "_early_dtack"}, 32'(dTACK_n), 32'd1);
            chk({t, "_early_buserr"}, 32'(buserr), 32'd0);
            chk({t, "_cyc_write"}, 32'(cyc_write), 32'(v.exp_write));
            chk({t, "_io_sel"}, 32'(io_sel), 32'(v.exp_io));
            if (v.kind == K_IO) io_ack = 1'b1;
            @(posedge clk);
            @(negedge clk);
            if (v.kind == K_ERR) begin
                chk({t, "_buserr"}, 32'(buserr), 32'd1);
                chk({t, "_err_dtack"}, 32'(dTACK_n), 32'd1);
            end else begin
                chk({t, "_dtack"}, 32'(dTACK_n), 32'd0);
                chk({t, "_no_buserr"}, 32'(buserr), 32'd0);
            end
        end
        AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1; io_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle({t, "_rel"});
        if (v.kind == K_IACK) chk({t, "_level_kept"}, 32'(iack_level), 32'(v.exp_level));
        $display("vector %0d: addr=%06h fc=%0d kind=%0d ticks=%0d done, miscompares so far %0d",
                 idx, v.addr, v.fc, v.kind, v.ticks, n_err);
    endtask

    vec_t vecs[11];

    initial begin
        int   lows;
        exp_t e;

        vecs[0]  = '{24'h001000, 3'd5, 1'b1, 1'b0, 1'b0, K_MEM,  0,    1'b0, 1'b0, 3'd0};
        vecs[1]  = '{24'hFC0000, 3'd5, 1'b0, 1'b0, 1'b1, K_MEM,  2,    1'b1, 1'b0, 3'd0};
        vecs[2]  = '{24'hE82000, 3'd5, 1'b1, 1'b0, 1'b0, K_IO,   10,   1'b0, 1'b1, 3'd0};
        vecs[3]  = '{24'hC00010, 3'd1, 1'b0, 1'b1, 1'b0, K_IO,   0,    1'b1, 1'b1, 3'd0};
        vecs[4]  = '{24'hBFFFFE, 3'd1, 1'b0, 1'b0, 1'b1, K_MEM,  0,    1'b1, 1'b0, 3'd0};
        vecs[5]  = '{24'hF00000, 3'd6, 1'b1, 1'b0, 1'b0, K_MEM,  2,    1'b0, 1'b0, 3'd0};
        vecs[6]  = '{24'hD00000, 3'd5, 1'b1, 1'b0, 1'b0, K_ERR,  255,  1'b0, 1'b1, 3'd0};
        vecs[7]  = '{24'hFFFFFA, 3'd7, 1'b1, 1'b1, 1'b1, K_IACK, 1000, 1'b0, 1'b0, 3'd5};
        vecs[8]  = '{24'hFFFFF2, 3'd7, 1'b1, 1'b1, 1'b0, K_IACK, 20,   1'b0, 1'b0, 3'd1};
        vecs[9]  = '{24'h000000, 3'd2, 1'b1, 1'b0, 1'b0, K_MEM,  0,    1'b0, 1'b0, 3'd0};
        vecs[10] = '{24'hEFFFFF, 3'd5, 1'b0, 1'b0, 1'b1, K_IO,   3,    1'b1, 1'b1, 3'd0};

        reset_n = 1'b0; AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1; rw_n = 1'b1;
        address = 24'h0; FC = 3'd0; io_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        chk("reset_iack_level", 32'(iack_level), 32'd0);
        chk("reset_cyc_write", 32'(cyc_write), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Strobes rising during ACK are ignored; then a new cycle after
        // AS_n has been high for exactly one clk.
        e = '{EV_DTACK, 1'b0, 1'b0, 3'd0};
        sb_q.push_back(e);
        @(negedge clk);
        address = 24'h002000; FC = 3'd5; rw_n = 1'b1; UDS_n = 1'b0; LDS_n = 1'b0; AS_n = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("hold_dtack", 32'(dTACK_n), 32'd0);
        UDS_n = 1'b1; LDS_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("hold_strobe%0d", i), 32'(dTACK_n), 32'd0);
        end
        AS_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("hold_rel_dtack", 32'(dTACK_n), 32'd1);
        sb_q.push_back(e);
        address = 24'h003000; UDS_n = 1'b0; AS_n = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("b2b_dtack", 32'(dTACK_n), 32'd0);
        AS_n = 1'b1; UDS_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle("b2b_rel");
        $display("sequence ack_hold/back_to_back done, miscompares so far %0d", n_err);

        // Abort: AS_n negates during WAIT of an IO cycle; no DTACK follows.
        @(negedge clk);
        address = 24'hC80000; FC = 3'd5; rw_n = 1'b1; LDS_n = 1'b0; AS_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_io_sel", 32'(io_sel), 32'd1);
        @(negedge clk);
        AS_n = 1'b1; LDS_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle("abort_rel");
        io_ack = 1'b1;
        lows = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!dTACK_n) lows++;
        end
        io_ack = 1'b0;
        chk("abort_no_dtack", 32'(lows), 32'd0);
        $display("sequence abort done, miscompares so far %0d", n_err);

        // Reset in the middle of a ROM write wait state.
        @(negedge clk);
        address = 24'hFC0000; FC = 3'd5; rw_n = 1'b0; UDS_n = 1'b0; LDS_n = 1'b0; AS_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_pre_write", 32'(cyc_write), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_idle("rst_async");
        chk("rst_cyc_write", 32'(cyc_write), 32'd0);
        chk("rst_iack_level", 32'(iack_level), 32'd0);
        @(negedge clk);
        UDS_n = 1'b1; LDS_n = 1'b1;    // AS_n stays low: no fresh start
        @(negedge clk);
        reset_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!dTACK_n) lows++;
        end
        chk("rst_no_dtack", 32'(lows), 32'd0);
        AS_n = 1'b1;
        @(negedge clk);
        check_idle("rst_end");
        $display("sequence reset_mid_cycle done, miscompares so far %0d", n_err);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
